// File: rtl/brq_fp_wb_arbiter.sv
// brq_fp_wb_arbiter: floating-point register file write-back arbiter.
//
// Two write-back sources compete for the single FP register file write port.
// The LSU (FP loads) is unbuffered. FPU results go into a small in-order FIFO.
// The LSU normally has priority. A full FIFO takes priority over the LSU, so
// the FPU can only be starved for a bounded time.
//
// An FPU result always spends at least one cycle in the FIFO. There is no
// bypass path around it. The granted write is registered onto rf_* one cycle
// after the accepting edge.
//
// Optional feature: define BRQ_FP_WB_SCOREBOARD_EN to build busy_o. busy_o
// holds one pending-write flag per FP register. An issue sets the flag and a
// completed write-back clears it. If both happen on the same edge, the set
// wins. Without the macro, busy_o is tied to zero and issue_i/issue_addr_i
// are ignored.

module brq_fp_wb_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [4:0]           fpu_addr_i,
    input  logic [DataWidth-1:0] fpu_data_i,

    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_data_i,

    input  logic                 issue_i,
    input  logic [4:0]           issue_addr_i,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    output logic [31:0]          busy_o,
    output logic [3:0]           fifo_cnt_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef struct packed {
        logic [4:0]           addr;
        logic [DataWidth-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GntNone,
        GntLsu,
        GntFifo
    } grant_e;

    wb_entry_t       fifo_mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [3:0]      cnt_q;
    logic            full;
    logic            empty;
    logic            fifo_push;
    logic            fifo_pop;
    grant_e          grant;
    wb_entry_t       fifo_head;

    // Advance a FIFO pointer, wrapping from the last entry back to 0.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full        = (cnt_q == 4'(FifoDepth));
    assign empty       = (cnt_q == 4'd0);
    assign fpu_ready_o = ~full;
    assign lsu_ready_o = ~full;
    assign fifo_cnt_o  = cnt_q;
    assign fifo_head   = fifo_mem[rd_ptr_q];

    // A full FIFO refuses new entries, even if the head leaves on the same edge.
    assign fifo_push = fpu_valid_i & ~full;

    // Choose the write-back source: the LSU while the FIFO has room, otherwise the FIFO head.
    always_comb begin
        // NOTE: assign the default first so that no path leaves grant unassigned and infers a latch.
        grant = GntNone;
        if (lsu_valid_i && !full) begin
            grant = GntLsu;
        end else if (!empty) begin
            grant = GntFifo;
        end
    end

    // The pop decision uses the occupancy from before this edge. A just-pushed entry therefore waits a cycle.
    assign fifo_pop = (grant == GntFifo);

    // FIFO storage: write the incoming FPU result at the write pointer.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset. Resetting the pointers and count is enough to discard stale entries.
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= '{addr: fpu_addr_i, data: fpu_data_i};
        end
    end

    // FIFO pointers and occupancy, with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state always uses non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + 4'(fifo_push) - 4'(fifo_pop);
        end
    end

    // Register the granted write onto the register file port. Address and data hold when idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o <= (grant != GntNone);
            unique case (grant)
                GntLsu: begin
                    rf_waddr_o <= lsu_addr_i;
                    rf_wdata_o <= lsu_data_i;
                end
                GntFifo: begin
                    rf_waddr_o <= fifo_head.addr;
                    rf_wdata_o <= fifo_head.data;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BRQ_FP_WB_SCOREBOARD_EN
    logic [31:0] busy_q;

    // Pending-write scoreboard: an issue sets the flag, a write-back clears it, and the set wins on a collision.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (issue_i && (issue_addr_i == 5'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (rf_we_o && (rf_waddr_o == 5'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;
`else
    // Scoreboard not built: busy_o is tied to zero and the issue inputs are ignored.
    logic unused_issue;
    assign unused_issue = ^{issue_i, issue_addr_i};
    assign busy_o       = '0;
`endif

endmodule
